// File: rtl/character_sequencer_pkg.sv
// rtl/character_sequencer_pkg.sv - shared states, screen constants and clamp helper
package character_pkg;

   localparam int POS_W                = 11;
   localparam int SCREEN_WIDTH_DEF     = 1024;
   localparam int SCREEN_HEIGHT_DEF    = 768;
   localparam int CHARACTER_WIDTH_DEF  = 64;
   localparam int CHARACTER_HEIGHT_DEF = 64;

   typedef enum logic [1:0] {
      S_OFF    = 2'd0,
      S_ACTIVE = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   // Unsigned saturation so the sprite's top-left never pushes it off-screen.
   function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] value,
                                                  input logic [POS_W-1:0] limit);
      return (value > limit) ? limit : value;
   endfunction

endpackage

// File: rtl/character_sequencer_if.sv
// rtl/character_sequencer_if.sv - position update handshake between game logic and sequencer
interface character_sequencer_if;
   import character_pkg::*;

   logic             pos_valid;
   logic [POS_W-1:0] pos_x;
   logic [POS_W-1:0] pos_y;
   logic             pos_ready;

   modport master (output pos_valid, output pos_x, output pos_y, input pos_ready);
   modport slave  (input pos_valid, input pos_x, input pos_y, output pos_ready);

endinterface

// File: rtl/character_sequencer_edge_detect.sv
// rtl/character_sequencer_edge_detect.sv - rising-edge detector with registered history
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic sig_i,
   output logic rise_o
);

   logic sig_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig_i;
      end
   end

   // Combinational output so the edge is visible in the same cycle the input rises.
   assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/character_sequencer.sv
// rtl/character_sequencer.sv - vblank-synchronous position commit and walk animation for one sprite
module character_sequencer
   import character_pkg::*;
#(
   parameter int CHARACTER_WIDTH  = CHARACTER_WIDTH_DEF,
   parameter int CHARACTER_HEIGHT = CHARACTER_HEIGHT_DEF,
   parameter int SCREEN_WIDTH     = SCREEN_WIDTH_DEF,
   parameter int SCREEN_HEIGHT    = SCREEN_HEIGHT_DEF,
   parameter int INIT_X           = 0,
   parameter int INIT_Y           = 0,
   parameter int ANIM_FRAMES      = 4,
   parameter int ANIM_DIV         = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start_game,
   input  logic                           vblnk,
   character_sequencer_if.slave           pos_if,
   output logic [POS_W-1:0]               xpos,
   output logic [POS_W-1:0]               ypos,
   output logic                           rotate,
   output logic                           en,
   output logic [$clog2(ANIM_FRAMES)-1:0] frame_sel,
   output logic                           frame_done
);

   localparam int FS_W  = $clog2(ANIM_FRAMES);
   localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

   localparam logic [POS_W-1:0] X_MAX      = POS_W'(SCREEN_WIDTH - CHARACTER_WIDTH);
   localparam logic [POS_W-1:0] Y_MAX      = POS_W'(SCREEN_HEIGHT - CHARACTER_HEIGHT);
   localparam logic [POS_W-1:0] X_INIT     = POS_W'(INIT_X);
   localparam logic [POS_W-1:0] Y_INIT     = POS_W'(INIT_Y);
   localparam logic [FS_W-1:0]  FRAME_LAST = FS_W'(ANIM_FRAMES - 1);
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(ANIM_DIV - 1);

   state_t           state_q, state_d;
   logic [POS_W-1:0] xpos_q, xpos_d;
   logic [POS_W-1:0] ypos_q, ypos_d;
   logic [POS_W-1:0] shadow_x_q, shadow_x_d;
   logic [POS_W-1:0] shadow_y_q, shadow_y_d;
   logic             pending_q, pending_d;
   logic             rotate_q, rotate_d;
   logic             en_q, en_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   logic [FS_W-1:0]  frame_q, frame_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             vblnk_rise;
   logic             moving;

   edge_detect u_vblnk_edge (
      .clk    (clk),
      .rst    (rst),
      .sig_i  (vblnk),
      .rise_o (vblnk_rise)
   );

   always_comb begin
      state_d    = state_q;
      xpos_d     = xpos_q;
      ypos_d     = ypos_q;
      shadow_x_d = shadow_x_q;
      shadow_y_d = shadow_y_q;
      pending_d  = pending_q;
      rotate_d   = rotate_q;
      frame_d    = frame_q;
      div_d      = div_q;
      moving     = 1'b0;

      case (state_q)
         S_OFF: begin
            pending_d = 1'b0;
            if (start_game) begin
               xpos_d   = X_INIT;
               ypos_d   = Y_INIT;
               rotate_d = 1'b0;
               frame_d  = '0;
               div_d    = '0;
               state_d  = S_ACTIVE;
            end
         end

         S_ACTIVE: begin
            if (pos_if.pos_valid && ready_q) begin
               shadow_x_d = clamp_pos(pos_if.pos_x, X_MAX);
               shadow_y_d = clamp_pos(pos_if.pos_y, Y_MAX);
               pending_d  = 1'b1;
            end
            if (vblnk_rise) begin
               state_d = S_COMMIT;
            end
         end

         S_COMMIT: begin
            if (pending_q) begin
               xpos_d    = shadow_x_q;
               ypos_d    = shadow_y_q;
               pending_d = 1'b0;
               moving    = (shadow_x_q != xpos_q) || (shadow_y_q != ypos_q);
               if (shadow_x_q < xpos_q) begin
                  rotate_d = 1'b1;
               end else if (shadow_x_q > xpos_q) begin
                  rotate_d = 1'b0;
               end
            end
            if (moving) begin
               if (div_q == DIV_LAST) begin
                  div_d   = '0;
                  frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + FS_W'(1);
               end else begin
                  div_d = div_q + DIV_W'(1);
               end
            end else begin
               div_d   = '0;
               frame_d = '0;
            end
            state_d = S_ACTIVE;
         end

         default: state_d = S_OFF;
      endcase

      // Leaving the game freezes the visible sprite and drops anything queued.
      if (!start_game) begin
         state_d   = S_OFF;
         pending_d = 1'b0;
         xpos_d    = xpos_q;
         ypos_d    = ypos_q;
         rotate_d  = rotate_q;
         frame_d   = frame_q;
         div_d     = div_q;
      end

      en_d    = (state_d != S_OFF);
      ready_d = (state_d == S_ACTIVE) && !pending_d;
      done_d  = (state_q == S_COMMIT) && start_game;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_OFF;
         xpos_q     <= X_INIT;
         ypos_q     <= Y_INIT;
         shadow_x_q <= '0;
         shadow_y_q <= '0;
         pending_q  <= 1'b0;
         rotate_q   <= 1'b0;
         en_q       <= 1'b0;
         ready_q    <= 1'b0;
         done_q     <= 1'b0;
         frame_q    <= '0;
         div_q      <= '0;
      end else begin
         state_q    <= state_d;
         xpos_q     <= xpos_d;
         ypos_q     <= ypos_d;
         shadow_x_q <= shadow_x_d;
         shadow_y_q <= shadow_y_d;
         pending_q  <= pending_d;
         rotate_q   <= rotate_d;
         en_q       <= en_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
         frame_q    <= frame_d;
         div_q      <= div_d;
      end
   end

   assign xpos             = xpos_q;
   assign ypos             = ypos_q;
   assign rotate           = rotate_q;
   assign en               = en_q;
   assign frame_sel        = frame_q;
   assign frame_done       = done_q;
   assign pos_if.pos_ready = ready_q;

endmodule

// File: doc/character_sequencer.md
# character_sequencer

Frame-synchronous controller for one character sprite drawer. It accepts position updates from game logic over a valid/ready handshake and holds them in a shadow register. At each vertical-blank start it commits the pending update to the drawer's `xpos`/`ypos`/`rotate`/`en` inputs, so a sprite never tears mid-frame. It also runs the walking-animation frame counter that selects the sprite bitmap.

## Interface
Parameters:
- `CHARACTER_WIDTH`, 64: sprite width in pixels; used for x clamping.
- `CHARACTER_HEIGHT`, 64: sprite height in pixels; used for y clamping.
- `SCREEN_WIDTH`, 1024: active horizontal pixels.
- `SCREEN_HEIGHT`, 768: active vertical lines.
- `INIT_X`, 0: reset / game-start x position.
- `INIT_Y`, 0: reset / game-start y position.
- `ANIM_FRAMES`, 4: number of animation frames. Must be ≥ 2.
- `ANIM_DIV`, 8: committed moving frames per animation step. Must be ≥ 1.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system/pixel clock.
- `rst`  in  1  asynchronous active-low reset.
- `start_game`  in  1  level; game running.
- `vblnk`  in  1  vertical blank from the VGA timing chain.
- `pos_valid`  in  1  game logic offers a new position.
- `pos_x`  in  11  requested x, top-left corner.
- `pos_y`  in  11  requested y, top-left corner.
- `pos_ready`  out  1  sequencer accepts the position this cycle.
- `xpos`  out  11  committed x to the drawer.
- `ypos`  out  11  committed y to the drawer.
- `rotate`  out  1  horizontal mirror, 1 = facing left.
- `en`  out  1  drawer enable.
- `frame_sel`  out  $clog2(ANIM_FRAMES)  animation frame index; forms the upper sprite-ROM address bits.
- `frame_done`  out  1  one-cycle pulse, high on the cycle after a commit.

## Operation
State machine `S_OFF`, `S_ACTIVE`, `S_COMMIT`:
- **S_OFF**
  - `en`=0 and `pos_ready`=0.
  - Pending flag is cleared.
  - On `start_game`=1, load `INIT_X`/`INIT_Y`, set `rotate`=0 and `frame_sel`=0, then go to `S_ACTIVE`.
- **S_ACTIVE**
  - `en`=1.
  - `pos_ready` = ~pending.
  - On `pos_valid && pos_ready`, store the clamped `pos_x`/`pos_y` in the shadow register and set pending.
  - A vblnk rising edge (`vblnk & ~vblnk_q`) moves to `S_COMMIT`.
- **S_COMMIT** (one cycle):
  - `pos_ready`=0.
  - If pending:
    - `xpos`/`ypos` ← shadow values.
    - `rotate` ← 1 if new x < old `xpos`, 0 if new x > old `xpos`, otherwise unchanged.
    - Moving = (new ≠ old) in x or y.
    - Clear pending.
  - If not pending: moving = 0.
  - Animation, when moving: increment `div_cnt`. When it reaches `ANIM_DIV`-1, clear it and advance `frame_sel`, wrapping `ANIM_FRAMES`-1 → 0.
  - Animation, when not moving: `div_cnt`=0 and `frame_sel`=0.
  - Pulse `frame_done`, then return to `S_ACTIVE`.
- `start_game`=0 in any state forces `S_OFF` on the next edge. `xpos`/`ypos` are held and the pending update is discarded.

Clamping is applied at accept time, with unsigned compares on 11 bits:
- x > `SCREEN_WIDTH`-`CHARACTER_WIDTH` → that value.
- y > `SCREEN_HEIGHT`-`CHARACTER_HEIGHT` → that value.

## Timing
- Reset values:
  - `xpos`=`INIT_X`, `ypos`=`INIT_Y`.
  - `rotate`=0, `en`=0, `frame_sel`=0, `pos_ready`=0, `frame_done`=0.
  - State `S_OFF`; `vblnk_q`=0, pending=0, `div_cnt`=0.
- All outputs are registered.
- Commit latency:
  - vblnk rises in cycle N, so the edge is seen in N.
  - N+1 is `S_COMMIT`.
  - New `xpos`/`ypos`/`rotate`/`frame_sel` and `frame_done`=1 are visible in N+2.
- `pos_ready` drops the cycle after an accept and stays low until the cycle after the commit.
- Valid arriving while `pos_ready`=0 is stalled; it is not lost.
- vblnk already high at `start_game` is not an edge; the first commit waits for the next rising edge.
- Reset asserted mid-operation returns all outputs to their reset values immediately, asynchronously.

## Structure
- Package `character_pkg`: `state_t` enum (S_OFF, S_ACTIVE, S_COMMIT) and the screen-size constants shared with the VGA timing.
- Sub-module `edge_detect`: registered rising-edge detector on `vblnk`, with the same async active-low reset.
- Everything else is one `always_ff` for state/registers plus one `always_comb` for next-state and clamp logic.

## Test plan
- **Reset:** hold `rst`=0 with `start_game`=1 → all outputs at reset values. Release → `en`=1 one cycle later; `xpos`=`INIT_X`.
- **Basic commit:** offer (100,200) mid-frame → accepted with `pos_ready`=0 afterwards; `xpos` unchanged until vblnk rises. `xpos`=100 and `ypos`=200 two cycles after the edge, with `frame_done` pulsing.
- **Direction:** commit x=100, then x=80 → `rotate`=1. Commit x=80 again → `rotate` stays 1 and `frame_sel`=0. Commit x=120 → `rotate`=0.
- **Clamp:** offer (1020,760) with defaults → committed (960,704).
- **Animation (`ANIM_DIV`=2, `ANIM_FRAMES`=4):** 8 consecutive moving commits → `frame_sel` sequence 0,1,1,2,2,3,3,0. One stationary frame → 0.
- **Stop:** drop `start_game` while an update is pending → `en`=0 next cycle and `pos_ready`=0. Restart → `INIT_X`/`INIT_Y`; the stale pending update is never committed.
